dsp_mac_sequencer: RTL and testbench
====================================

# dsp_mac_sequencer

Sequences one DSP slice through signed dot-product jobs: accepts a job length, streams operand pairs into the slice over a valid/ready handshake, and drives the slice control and clock-enable pins so the first product loads P and later products accumulate into P. It returns the 48-bit sum on a valid/ready result port. It sits between the operand source and a single DSP instance. It owns that instance's A, B, OPMODE, ALUMODE, INMODE, CARRYINSEL, CEA2, CEB2, CEM, CECTRL, CEP and RSTP.

## Interface
- LEN_W, 16, width of job length.
- PIPE_LAT, 4, cycles from an operand-accept edge until the P register holds that operand's contribution. Legal range 2..8.
- OPM_DLY, 2, stage of the control pipe that drives OPMODE/CECTRL. Must be < PIPE_LAT.
- clk  in  1  clock; all logic is on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs, sampled with start.
- busy  out  1  high in every state except IDLE.
- in_valid / in_ready  in / out  1 / 1  operand handshake.
- in_a  in  27  signed operand; sign-extended to 30 bits on dsp_A.
- in_b  in  18  signed operand.
- res_valid / res_ready  out / in  1 / 1  result handshake.
- res_data  out  48  accumulated sum (two's complement).
- dsp_A  out  30  DSP A input.
- dsp_B  out  18  DSP B input.
- dsp_CEA2, dsp_CEB2  out  1  DSP input-register enables.
- dsp_CEM, dsp_CECTRL, dsp_CEP  out  1  DSP multiplier-register, control-register and P-register enables.
- dsp_RSTP  out  1  DSP P-register reset.
- dsp_OPMODE  out  9  DSP operation mode.
- dsp_ALUMODE  out  4  DSP ALU mode.
- dsp_INMODE  out  5  DSP input mode.
- dsp_CARRYINSEL  out  3  DSP carry-in select.
- dsp_P  in  48  DSP P output.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with len≠0 → latch len into the remaining counter, go to RUN.
  - start=1 with len=0 → go to DONE with res_data=0; no DSP activity.
- RUN:
  - in_ready=1.
  - Each accept (in_valid&in_ready) drives dsp_A/dsp_B and pulses dsp_CEA2/dsp_CEB2 for that cycle only.
  - Each accept pushes {v=1, first, last} into the control pipe and decrements the counter.
  - The accept with counter=1 carries last=1 and moves the FSM to DRAIN.
- DRAIN: in_ready=0. Wait until the last tag exits stage PIPE_LAT, then capture dsp_P into res_data and go to DONE.
- DONE: res_valid=1. On res_ready → IDLE. A start in the same cycle is ignored.
- Control pipe: shift register PIPE_LAT deep; bubbles carry v=0.
- Stage OPM_DLY drives the slice controls:
  - dsp_OPMODE = 9'h005 (W=0, Z=0, Y=M, X=M: P=M) when first=1, else 9'h025 (Z=P: P=P+M).
  - dsp_CECTRL = v.
- Stage PIPE_LAT-1 drives dsp_CEP = v, so bubbles hold P.
- Constant outputs:
  - dsp_ALUMODE=0 (add), dsp_INMODE=0, dsp_CARRYINSEL=0.
  - dsp_CEM=1.
  - dsp_RSTP=RST.
- Arithmetic is modulo 2^48; no overflow flag.
- Reset:
  - All state and pipe contents clear. FSM goes to IDLE.
  - busy, in_ready, res_valid, dsp_CE* = 0. res_data=0, dsp_A=0, dsp_B=0, dsp_OPMODE=9'h005.
  - Reset mid-job abandons the job; no result is emitted.

## Timing
- Start accepted at edge t → busy and in_ready high from cycle t+1.
- Last operand accepted at edge k → res_valid high in cycle k+PIPE_LAT+1.
- in_valid gaps are allowed; total latency grows only by the gap count.
- Back-to-back jobs: minimum one IDLE cycle between jobs.
- res_data is stable while res_valid=1 and res_ready=0.

## Structure
- Package dsp_seq_pkg holds:
  - state enum;
  - OPM_LOAD=9'h005 and OPM_ACC=9'h025;
  - ALU_ADD=4'h0;
  - control-tag struct {v, first, last}.
- Sub-module dsp_seq_ctrl_pipe: parameterised tag shift register with taps at OPM_DLY and PIPE_LAT-1, plus an exit flag at PIPE_LAT.

## Test plan
- len=4; a={1,2,3,4}, b={5,6,7,8}, no gaps → res_data=70 exactly PIPE_LAT+1 cycles after the 4th accept. dsp_OPMODE=005 exactly once, then 025 three times.
- len=1, a=-3, b=7 → res_data=48'hFFFF_FFFF_FFEB.
- len=3 (all pairs 2×2) with 2-cycle in_valid gaps → res_data=12, and dsp_CEP=0 during each bubble.
- len=0 → res_valid the cycle after start with res_data=0; dsp_CEA2 never asserts.
- Result held 5 cycles with res_ready=0, start pulsed during DONE → res_data stable and start ignored; a new job starts only after the return to IDLE.
- RST asserted mid-RUN of a len=8 job → next cycle in IDLE with all outputs at reset values. A following len=2 job, a={1,1}, b={1,1}, returns 2.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// Shared types and DSP control constants for the MAC sequencer.
package dsp_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [8:0] OPM_LOAD = 9'h005;
    localparam logic [8:0] OPM_ACC  = 9'h025;
    localparam logic [3:0] ALU_ADD  = 4'h0;

    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } ctrl_tag_t;

    function automatic logic [29:0] sext_a(input logic [26:0] a);
        return {{3{a[26]}}, a};
    endfunction

endpackage

// File: rtl/dsp_seq_ctrl_pipe.sv
// Control-tag delay line that follows each operand through the DSP registers.
module dsp_seq_ctrl_pipe
    import dsp_seq_pkg::*;
#(
    parameter int PIPE_LAT = 4,
    parameter int OPM_DLY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  ctrl_tag_t  push_tag,
    output logic [8:0] opmode,
    output logic       cectrl,
    output logic       cep,
    output logic       exit_last
);

    ctrl_tag_t  stage_q [1:PIPE_LAT];
    ctrl_tag_t  stage_d [1:PIPE_LAT];
    logic [8:0] opmode_q;
    logic [8:0] opmode_d;

    // Shift next-state, with OPMODE pre-decoded so it lands alongside its tag
    always_comb begin
        stage_d[1] = push_tag;
        for (int i = 2; i <= PIPE_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        opmode_d = stage_d[OPM_DLY].first ? OPM_LOAD : OPM_ACC;
    end

    // Tag pipe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= PIPE_LAT; i++) begin
                stage_q[i] <= '0;
            end
            opmode_q <= OPM_LOAD;
        end else begin
            stage_q  <= stage_d;
            opmode_q <= opmode_d;
        end
    end

    assign opmode    = opmode_q;
    assign cectrl    = stage_q[OPM_DLY].v;
    assign cep       = stage_q[PIPE_LAT-1].v;
    assign exit_last = stage_q[PIPE_LAT].v & stage_q[PIPE_LAT].last;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP slice through signed dot-product jobs and returns the 48-bit sum.
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 4,
    parameter int OPM_DLY  = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [26:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [29:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic             dsp_CEA2,
    output logic             dsp_CEB2,
    output logic             dsp_CEM,
    output logic             dsp_CECTRL,
    output logic             dsp_CEP,
    output logic             dsp_RSTP,
    output logic [8:0]       dsp_OPMODE,
    output logic [3:0]       dsp_ALUMODE,
    output logic [4:0]       dsp_INMODE,
    output logic [2:0]       dsp_CARRYINSEL,
    input  logic [47:0]      dsp_P
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [47:0]      res_data_q, res_data_d;
    logic [29:0]      a_q, a_d;
    logic [17:0]      b_q, b_d;
    logic             ce_in_q, ce_in_d;
    logic             cem_q;
    ctrl_tag_t        push_tag;
    logic             accept;
    logic             exit_last;

    assign accept = in_valid & in_ready_q;

    // Next-state and output decode; status outputs follow the next state so they are registered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        res_data_d = res_data_q;
        a_d        = a_q;
        b_d        = b_q;
        ce_in_d    = 1'b0;
        push_tag   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = S_RUN;
                        cnt_d   = len;
                        first_d = 1'b1;
                    end else begin
                        state_d    = S_DONE;
                        res_data_d = 48'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept) begin
                    a_d      = sext_a(in_a);
                    b_d      = in_b;
                    ce_in_d  = 1'b1;
                    push_tag = '{v: 1'b1, first: first_q, last: (cnt_q == LEN_W'(1))};
                    cnt_d    = cnt_q - LEN_W'(1);
                    first_d  = 1'b0;
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (exit_last) begin
                    res_data_d = dsp_P;
                    state_d    = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_RUN);
        res_valid_d = (state_d == S_DONE);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 48'd0;
            a_q         <= 30'd0;
            b_q         <= 18'd0;
            ce_in_q     <= 1'b0;
            cem_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ce_in_q     <= ce_in_d;
            cem_q       <= 1'b1;
        end
    end

    dsp_seq_ctrl_pipe #(
        .PIPE_LAT (PIPE_LAT),
        .OPM_DLY  (OPM_DLY)
    ) u_pipe (
        .clk       (clk),
        .rst       (RST),
        .push_tag  (push_tag),
        .opmode    (dsp_OPMODE),
        .cectrl    (dsp_CECTRL),
        .cep       (dsp_CEP),
        .exit_last (exit_last)
    );

    assign busy           = busy_q;
    assign in_ready       = in_ready_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign dsp_A          = a_q;
    assign dsp_B          = b_q;
    assign dsp_CEA2       = ce_in_q;
    assign dsp_CEB2       = ce_in_q;
    assign dsp_CEM        = cem_q;
    assign dsp_RSTP       = RST;
    assign dsp_ALUMODE    = ALU_ADD;
    assign dsp_INMODE     = 5'd0;
    assign dsp_CARRYINSEL = 3'd0;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Randomised self-checking bench: sequencer driving a behavioural DSP slice, sums from plain arithmetic.
module tb_dsp_mac_sequencer;

    localparam int LEN_W    = 16;
    localparam int PIPE_LAT = 4;
    localparam int OPM_DLY  = 2;

    logic             clk = 1'b0;
    logic             RST;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [26:0]      in_a;
    logic [17:0]      in_b;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;
    logic [29:0]      dsp_A;
    logic [17:0]      dsp_B;
    logic             dsp_CEA2, dsp_CEB2, dsp_CEM, dsp_CECTRL, dsp_CEP, dsp_RSTP;
    logic [8:0]       dsp_OPMODE;
    logic [3:0]       dsp_ALUMODE;
    logic [4:0]       dsp_INMODE;
    logic [2:0]       dsp_CARRYINSEL;
    logic [47:0]      dsp_P;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic signed [26:0] op_a [0:15];
    logic signed [17:0] op_b [0:15];

    dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT), .OPM_DLY(OPM_DLY)) dut (
        .clk(clk), .RST(RST), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_CEA2(dsp_CEA2), .dsp_CEB2(dsp_CEB2),
        .dsp_CEM(dsp_CEM), .dsp_CECTRL(dsp_CECTRL), .dsp_CEP(dsp_CEP), .dsp_RSTP(dsp_RSTP),
        .dsp_OPMODE(dsp_OPMODE), .dsp_ALUMODE(dsp_ALUMODE), .dsp_INMODE(dsp_INMODE),
        .dsp_CARRYINSEL(dsp_CARRYINSEL), .dsp_P(dsp_P)
    );

    always #5 clk = ~clk;

    // Edge counter
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural DSP slice: A2/B2 -> M -> P, with a registered OPMODE selecting load or accumulate
    logic signed [29:0] a2_m = '0;
    logic signed [17:0] b2_m = '0;
    logic [47:0]        m_m = '0;
    logic [47:0]        p_m = '0;
    logic [8:0]         ctrl_m = 9'h005;
    always @(posedge clk) begin
        if (dsp_CEA2) a2_m <= dsp_A;
        if (dsp_CEB2) b2_m <= dsp_B;
        if (dsp_CEM)  m_m  <= 48'(longint'(a2_m) * longint'(b2_m));
        if (dsp_CECTRL) ctrl_m <= dsp_OPMODE;
        if (dsp_RSTP) p_m <= '0;
        else if (dsp_CEP) p_m <= (ctrl_m[6:4] == 3'b010) ? p_m + m_m : m_m;
    end
    assign dsp_P = p_m;

    // Running activity totals on the slice control pins
    int tot_cep = 0, tot_cea = 0, tot_load = 0, tot_acc = 0;
    always @(negedge clk) begin
        if (dsp_CEP)  tot_cep <= tot_cep + 1;
        if (dsp_CEA2) tot_cea <= tot_cea + 1;
        if (dsp_CECTRL && dsp_OPMODE == 9'h005) tot_load <= tot_load + 1;
        if (dsp_CECTRL && dsp_OPMODE == 9'h025) tot_acc  <= tot_acc + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check_eq({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check_eq({tag, "_ce"}, 64'({dsp_CEA2, dsp_CEB2, dsp_CEM, dsp_CECTRL, dsp_CEP}), 64'd0);
        check_eq({tag, "_res_data"}, 64'(res_data), 64'd0);
        check_eq({tag, "_dsp_ab"}, 64'({dsp_A, dsp_B}), 64'd0);
        check_eq({tag, "_opmode"}, 64'(dsp_OPMODE), 64'h005);
        check_eq({tag, "_rstp"}, 64'(dsp_RSTP), 64'd1);
        check_eq({tag, "_consts"}, 64'({dsp_ALUMODE, dsp_INMODE, dsp_CARRYINSEL}), 64'd0);
    endtask

    // One job from op_a/op_b[0:n-1]; gap = idle cycles after each accept; hold = cycles result is left waiting
    task automatic run_job(input string tag, input int n, input int gap, input int hold);
        logic [47:0] exp_sum;
        int idx, g, t, start_edge, last_edge, exp_edge;
        int b_cep, b_cea, b_load, b_acc;
        exp_sum = '0;
        for (int i = 0; i < n; i++) exp_sum += 48'(longint'(op_a[i]) * longint'(op_b[i]));
        b_cep = tot_cep; b_cea = tot_cea; b_load = tot_load; b_acc = tot_acc;
        start = 1'b1; len = LEN_W'(n); start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy"}, 64'(busy), 64'd1);
        idx = 0; g = 0; t = 0; last_edge = start_edge;
        while (idx < n && t < 1000) begin
            if (g > 0) begin
                in_valid = 1'b0; g--;
            end else begin
                in_valid = 1'b1; in_a = op_a[idx]; in_b = op_b[idx];
                if (in_ready) begin idx++; last_edge = cyc + 1; g = gap; end
            end
            @(negedge clk); t++;
        end
        in_valid = 1'b0;
        t = 0;
        while (!res_valid && t < 200) begin @(negedge clk); t++; end
        check_eq({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        exp_edge = (n == 0) ? start_edge : last_edge + PIPE_LAT;
        check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_edge));
        check_eq({tag, "_res_data"}, 64'(res_data), 64'(exp_sum));
        check_eq({tag, "_cea_pulses"}, 64'(tot_cea - b_cea), 64'(n));
        check_eq({tag, "_cep_pulses"}, 64'(tot_cep - b_cep), 64'(n));
        check_eq({tag, "_opm_load"}, 64'(tot_load - b_load), 64'((n == 0) ? 0 : 1));
        check_eq({tag, "_opm_acc"}, 64'(tot_acc - b_acc), 64'((n == 0) ? 0 : n - 1));
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0; start = (h == 2); len = LEN_W'(5);
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            check_eq({tag, "_hold_data"}, 64'(res_data), 64'(exp_sum));
        end
        res_ready = 1'b1; start = (hold > 0); len = LEN_W'(5);
        @(negedge clk);
        res_ready = 1'b0; start = 1'b0;
        check_eq({tag, "_ack_valid"}, 64'(res_valid), 64'd0);
        check_eq({tag, "_ack_busy"}, 64'(busy), 64'd0);
        @(negedge clk);
        check_eq({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n, gap;
        RST = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin op_a[i] = 27'(i + 1); op_b[i] = 18'(i + 5); end
        run_job("len4", 4, 0, 0);

        op_a[0] = -27'sd3; op_b[0] = 18'sd7;
        run_job("neg", 1, 0, 0);

        for (int i = 0; i < 3; i++) begin op_a[i] = 27'sd2; op_b[i] = 18'sd2; end
        run_job("gaps", 3, 2, 0);

        run_job("len0", 0, 0, 0);

        for (int i = 0; i < 2; i++) begin op_a[i] = 27'(i + 9); op_b[i] = -18'sd4; end
        run_job("hold", 2, 0, 5);

        start = 1'b1; len = LEN_W'(8);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 27'sd5; in_b = 18'sd5;
        repeat (3) @(negedge clk);
        in_valid = 1'b0; RST = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        RST = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin op_a[i] = 27'sd1; op_b[i] = 18'sd1; end
        run_job("after_rst", 2, 0, 0);

        for (int j = 0; j < 6; j++) begin
            n   = int'($urandom_range(12, 1));
            gap = int'($urandom_range(3, 0));
            for (int i = 0; i < n; i++) begin
                op_a[i] = 27'($urandom);
                op_b[i] = 18'($urandom);
            end
            run_job($sformatf("rand%0d", j), n, gap, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
